sync_ff_sync_nb_filt: RTL

Parametrised multi-channel synchroniser for the 64-QAM modulator's asynchronous control inputs (buttons, external enables, mode straps). Each channel passes through a STAGES-deep flip-flop chain into clk. It is then glitch-filtered: a change must hold for FILT_CNT consecutive cycles. The block also emits one-cycle rise and fall pulses on the filtered value. It sits at the modulator's input boundary and feeds the control FSMs directly.

---
 rtl/sync_ff_sync_nb_filt_if.sv | 30 +++
 rtl/sync_ff_sync_nb_filt.sv | 92 +++++++++
 2 files changed

// File: rtl/sync_ff_sync_nb_filt_if.sv
// Signal bundle for the multi-channel synchroniser and glitch filter.
// The DUT connects through the slave modport; whatever drives data_in uses master.
interface sync_ff_sync_nb_filt_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             change_any;

    modport master (
        output data_in,
        input  data_sync,
        input  data_out,
        input  rise_pulse,
        input  fall_pulse,
        input  change_any
    );

    modport slave (
        input  data_in,
        output data_sync,
        output data_out,
        output rise_pulse,
        output fall_pulse,
        output change_any
    );
endinterface

// File: rtl/sync_ff_sync_nb_filt.sv
// Multi-channel synchroniser for asynchronous control inputs.
// Per channel: an N-flop sync chain, a hold-time glitch filter, and registered edge pulses.
module sync_ff_sync_nb_filt #(
    parameter int               WIDTH    = 4,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    sync_ff_sync_nb_filt_if.slave   bus
);

    localparam int               CNT_W   = $clog2(FILT_CNT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CNT - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_ff_sync_nb_filt: STAGES must be at least 2");
        end
        if (FILT_CNT < 1) begin : g_bad_filt
            $error("sync_ff_sync_nb_filt: FILT_CNT must be at least 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_ff_sync_nb_filt: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] stage [STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             any_q;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= RST_VAL;
            end
        end else begin
            stage[0] <= bus.data_in;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign sync_q = stage[STAGES-1];

    // A channel commits once its synchronised value has disagreed with data_out
    // for FILT_CNT consecutive edges, including the current one.
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (sync_q[i] != out_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q[i] == out_q[i] || upd[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            out_q  <= (out_q & ~upd) | (sync_q & upd);
            rise_q <= upd & sync_q;
            fall_q <= upd & ~sync_q;
            any_q  <= |upd;
        end
    end

    assign bus.data_sync  = sync_q;
    assign bus.data_out   = out_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.change_any = any_q;

endmodule
